// File: rtl/gate_ctrl.sv
// Gate-time controller for a frequency counter: opens a 1 s / 0.1 s / 10 ms
// counting window, then holds the display before the next measurement.
module gate_ctrl #(
   parameter int unsigned CLK_HZ      = 50000000,
   parameter int unsigned HOLD_CYCLES = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] range,
   output logic       gate_out,
   output logic       done,
   output logic       aborted,
   output logic [1:0] range_q,
   output logic [1:0] dp_pos,
   output logic [7:0] meas_cnt
);

   localparam int unsigned CW        = 32;
   localparam int unsigned GL_1S     = CLK_HZ;
   localparam int unsigned GL_100MS  = CLK_HZ / 10;
   localparam int unsigned GL_10MS   = CLK_HZ / 100;
   localparam int unsigned HOLD_LAST = HOLD_CYCLES - 1;

   typedef enum logic [1:0] {IDLE, GATE, HOLD} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [CW-1:0] gl_last;
   logic          start, fin, abort;
   logic          gate_nxt, done_nxt, aborted_nxt;
   logic [1:0]    range_nxt, dp_nxt;
   logic [7:0]    meas_nxt;

   // Terminal count of the current gate, selected by the latched range
   always_comb begin
      gl_last = CW'(GL_1S - 1);
      case (range_q)
         2'b01:   gl_last = CW'(GL_100MS - 1);
         2'b10:   gl_last = CW'(GL_10MS - 1);
         default: gl_last = CW'(GL_1S - 1);
      endcase
   end

   // State, cycle counter and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         gate_out <= 1'b0;
         done     <= 1'b0;
         aborted  <= 1'b0;
         range_q  <= 2'b00;
         dp_pos   <= 2'b00;
         meas_cnt <= 8'd0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         gate_out <= gate_nxt;
         done     <= done_nxt;
         aborted  <= aborted_nxt;
         range_q  <= range_nxt;
         dp_pos   <= dp_nxt;
         meas_cnt <= meas_nxt;
      end
   end

   // Next state; en low in GATE wins over terminal count
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      fin       = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (en) begin
               state_nxt = GATE;
               start     = 1'b1;
            end
         end
         GATE: begin
            if (!en) begin
               state_nxt = IDLE;
               abort     = 1'b1;
            end else if (cnt == gl_last) begin
               state_nxt = HOLD;
               fin       = 1'b1;
            end
         end
         HOLD: begin
            if (cnt == CW'(HOLD_LAST)) begin
               if (en) begin
                  state_nxt = GATE;
                  start     = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      cnt_nxt = ((state_nxt != state) || (state == IDLE)) ? '0 : cnt + CW'(1);
   end

   // Next values of the registered outputs
   always_comb begin
      gate_nxt    = (state_nxt == GATE);
      done_nxt    = fin;
      aborted_nxt = abort;
      meas_nxt    = fin ? meas_cnt + 8'd1 : meas_cnt;
      range_nxt   = range_q;
      if (start) range_nxt = (range == 2'b11) ? 2'b00 : range;
      // Decimal-point index numerically equals the stored range code
      dp_nxt      = range_nxt;
   end

endmodule

// File: tb/tb_gate_ctrl.sv
// Scoreboard bench for gate_ctrl: stimulus queues expected gate events, a
// monitor measures each gate window and compares on its falling edge.
module tb_gate_ctrl;

   localparam int unsigned CLK_HZ      = 1000;
   localparam int unsigned HOLD_CYCLES = 50;
   localparam int K_NONE = 0, K_DONE = 1, K_ABORT = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic [1:0] range = 2'b00;
   logic       gate_out, done, aborted;
   logic [1:0] range_q, dp_pos;
   logic [7:0] meas_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         kind;
      int         width;
      logic [1:0] rq;
      logic [1:0] dp;
      logic [7:0] cnt;
   } ev_t;

   ev_t exp_q[$];

   gate_ctrl #(.CLK_HZ(CLK_HZ), .HOLD_CYCLES(HOLD_CYCLES)) dut (
      .clk(clk), .rst(rst), .en(en), .range(range),
      .gate_out(gate_out), .done(done), .aborted(aborted),
      .range_q(range_q), .dp_pos(dp_pos), .meas_cnt(meas_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic push(input int kind, input int width, input int rq, input int cnt);
      ev_t e;
      e.kind = kind; e.width = width; e.rq = 2'(rq); e.dp = 2'(rq); e.cnt = 8'(cnt);
      exp_q.push_back(e);
   endtask

   task automatic wait_gate(input logic lvl, input int budget);
      int n = 0;
      while (gate_out !== lvl && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (gate_out !== lvl) chk("wait_gate_timeout", int'(gate_out), int'(lvl));
   endtask

   // Monitor: measure gate width and low gap, score each gate at its fall
   int   width = 0;
   int   low_cnt = 0;
   int   last_gap = 0;
   logic prev_gate = 1'b0;

   always @(negedge clk) begin
      int kind;
      ev_t e;
      kind = (done ? 1 : 0) + (aborted ? 2 : 0);
      if (gate_out) begin
         if (!prev_gate) begin
            last_gap = low_cnt;
            width = 0;
         end
         width++;
         low_cnt = 0;
      end else begin
         low_cnt++;
      end
      if (!gate_out && prev_gate) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_gate", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("kind", kind, e.kind);
            chk("width", width, e.width);
            chk("range_q", int'(range_q), int'(e.rq));
            chk("dp_pos", int'(dp_pos), int'(e.dp));
            chk("meas_cnt", int'(meas_cnt), int'(e.cnt));
         end
      end else if (kind != 0) begin
         chk("stray_pulse", kind, 0);
      end
      prev_gate = gate_out;
   end

   initial begin
      // Reset state
      #23;
      chk("rst_gate", int'(gate_out), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_aborted", int'(aborted), 0);
      chk("rst_range_q", int'(range_q), 0);
      chk("rst_dp_pos", int'(dp_pos), 0);
      chk("rst_meas", int'(meas_cnt), 0);

      // 1 s gate; range moved to 10 mid-gate is ignored until the next gate
      @(negedge clk);
      en = 1'b1; rst = 1'b1;
      push(K_DONE, 1000, 0, 1);
      wait_gate(1'b1, 5);
      repeat (500) @(negedge clk);
      range = 2'b10;
      push(K_DONE, 10, 2, 2);
      wait_gate(1'b0, 600);
      wait_gate(1'b1, 100);
      range = 2'b01;
      push(K_DONE, 100, 1, 3);
      @(negedge clk);
      chk("hold_gap", last_gap, 50);
      wait_gate(1'b0, 50);
      wait_gate(1'b1, 100);
      range = 2'b11;
      push(K_DONE, 1000, 0, 4);
      wait_gate(1'b0, 200);
      wait_gate(1'b1, 100);
      range = 2'b00;

      // Abort at gate cycle 300
      push(K_ABORT, 300, 0, 4);
      wait_gate(1'b0, 1100);
      wait_gate(1'b1, 100);
      repeat (299) @(negedge clk);
      en = 1'b0;
      repeat (5) @(negedge clk);
      range = 2'b01;
      repeat (3) @(negedge clk);
      chk("idle_gate", int'(gate_out), 0);
      chk("idle_range_q", int'(range_q), 0);
      chk("idle_dp_pos", int'(dp_pos), 0);
      chk("idle_meas", int'(meas_cnt), 4);

      // en low exactly on the terminal cycle of a 100-cycle gate
      en = 1'b1;
      push(K_ABORT, 100, 1, 4);
      wait_gate(1'b1, 5);
      repeat (99) @(negedge clk);
      en = 1'b0;
      repeat (3) @(negedge clk);

      // Asynchronous reset mid-gate
      range = 2'b10; en = 1'b1;
      push(K_NONE, 6, 0, 0);
      wait_gate(1'b1, 5);
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_gate", int'(gate_out), 0);
      chk("arst_range_q", int'(range_q), 0);
      chk("arst_dp_pos", int'(dp_pos), 0);
      chk("arst_meas", int'(meas_cnt), 0);
      @(negedge clk);
      #2 rst = 1'b1;

      // 256 completed gates wrap meas_cnt back to 0
      for (int i = 0; i < 256; i++) push(K_DONE, 10, 2, (i + 1) % 256);
      for (int i = 0; i < 256; i++) begin
         wait_gate(1'b1, 100);
         wait_gate(1'b0, 100);
      end
      en = 1'b0;
      repeat (100) @(negedge clk);
      chk("wrap_meas", int'(meas_cnt), 0);
      chk("end_gate", int'(gate_out), 0);
      chk("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gate_ctrl.md
GATE_CTRL -- requirements
Module: gate_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000: clk frequency in Hz; must be a multiple of 100.
REQ-002 SHALL have parameter HOLD_CYCLES, default 25000000: display-hold length in clk cycles, >=1.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  run enable; low aborts or holds off measurement.
REQ-006 SHALL have port range  input  2  gate select: 00 = 1 s, 01 = 0.1 s, 10 = 10 ms, 11 = treated as 00.
REQ-007 SHALL have port gate_out  output  1  counting window to downstream BCD counter, registered.
REQ-008 SHALL have port done  output  1  one-cycle pulse, completed gate.
REQ-009 SHALL have port aborted  output  1  one-cycle pulse, gate cut short by en low.
REQ-010 SHALL have port range_q  output  2  range latched at gate start, with 11 stored as 00.
REQ-011 SHALL have port dp_pos  output  2  decimal-point digit index for display: 0 for range_q 00, 1 for 01, 2 for 10.
REQ-012 SHALL have port meas_cnt  output  8  count of completed gates.

Function
REQ-013 SHALL implement FSM states IDLE, GATE, HOLD.
REQ-014 SHALL use one 32-bit cycle counter, cleared on every state change.
REQ-015 SHALL set gate length GL as follows: CLK_HZ for range_q 00, CLK_HZ/10 for 01, CLK_HZ/100 for 10.
REQ-016 SHALL, in IDLE with en=1, on the next edge enter GATE, set gate_out=1, latch range into range_q and clear the counter.
REQ-017 SHALL hold gate_out high for exactly GL clk cycles.
REQ-018 SHALL, in GATE, enter HOLD on the edge where counter==GL-1 and en=1, set gate_out=0, pulse done for that one cycle and increment meas_cnt.
REQ-019 SHALL wrap meas_cnt from 255 to 0.
REQ-020 SHALL, in GATE with en=0, on the next edge go to IDLE, set gate_out=0, pulse aborted, and leave done and meas_cnt unchanged.
REQ-021 SHALL give en=0 priority over terminal count when both occur on the same edge.
REQ-022 SHALL keep gate_out=0 in HOLD for HOLD_CYCLES cycles regardless of en.
REQ-023 SHALL, at counter==HOLD_CYCLES-1, go to GATE if en=1 (re-latching range) or to IDLE if en=0.
REQ-024 SHALL ignore range changes while in GATE or HOLD.
REQ-025 SHALL leave range_q and dp_pos unchanged after abort or in IDLE.
REQ-026 SHALL keep gate_out low in IDLE and HOLD.
REQ-027 SHALL keep gate_out glitch-free, driven directly from a flop.
REQ-028 SHALL never assert done and aborted in the same cycle.

Reset
REQ-029 SHALL, while rst=0, immediately force state=IDLE, counter=0, gate_out=0, done=0, aborted=0, range_q=00, dp_pos=0 and meas_cnt=0, independent of clk.
REQ-030 SHALL, on reset mid-GATE, drop gate_out asynchronously with no done or aborted pulse.
REQ-031 SHALL, after rst release with en=1, start the first gate on the first clk edge.

Verification (CLK_HZ=1000, HOLD_CYCLES=50)
REQ-032 SHALL cover: range=00, en=1 -> gate_out high exactly 1000 cycles, done pulse 1 cycle at fall, meas_cnt=1, then 50 low cycles, then next gate.
REQ-033 SHALL cover: range=01 then 10 -> gate widths 100 and 10 cycles; dp_pos 1 then 2.
REQ-034 SHALL cover: range=11 -> 1000-cycle gate, range_q=00, dp_pos=0.
REQ-035 SHALL cover: range changed 00->10 at gate cycle 500 -> gate still 1000 cycles; next gate 10 cycles.
REQ-036 SHALL cover: en low at gate cycle 300 -> gate_out low next edge, aborted pulse, no done, meas_cnt unchanged; en low exactly at terminal cycle -> aborted, not done.
REQ-037 SHALL cover: rst low mid-GATE -> all outputs 0 asynchronously; 256 completed gates -> meas_cnt wraps to 0.
